// File: rtl/osc_window_controller.sv
// osc_window_controller: gates the oscillator counter window, samples its count and steps the DAC code to lock
module osc_window_controller #(
    parameter int CNT_W         = 8,
    parameter int CODE_W        = 6,
    parameter int WINDOW_CYCLES = 200,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [CNT_W-1:0]  i_target,
    input  logic [3:0]        i_tol,
    input  logic [CNT_W-1:0]  i_counter,
    output logic              o_count_done,
    output logic [CODE_W-1:0] o_ctrl_code,
    output logic [CNT_W-1:0]  o_sample,
    output logic              o_sample_valid,
    output logic              o_locked
);
    localparam int LW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, SETTLE, EVAL} state_t;

    state_t              r_state;
    logic [15:0]         r_cnt;
    logic [CNT_W-1:0]    r_sync1, r_sync2;
    logic [CNT_W-1:0]    r_sample;
    logic [CODE_W-1:0]   r_code;
    logic [LW-1:0]       r_lock_cnt;
    logic                r_count_done, r_valid, r_locked;

    logic [15:0]         w_lim;
    logic                w_last, w_hi, w_lo, w_code_max, w_code_min;
    logic signed [CNT_W:0] w_err, w_tol;
    logic [LW-1:0]       w_lock_nxt;

    always_comb begin
        w_lim      = (r_state == CLEAR) ? 16'(CLEAR_CYCLES - 1) :
                     (r_state == COUNT) ? 16'(WINDOW_CYCLES - 1) : 16'(SETTLE_CYCLES - 1);
        w_last     = r_cnt == w_lim;
        w_err      = $signed({1'b0, r_sync2}) - $signed({1'b0, i_target});
        w_tol      = $signed({{(CNT_W - 3){1'b0}}, i_tol});
        w_hi       = w_err > w_tol;
        w_lo       = w_err < -w_tol;
        w_code_max = &r_code;
        w_code_min = ~|r_code;
        w_lock_nxt = (r_lock_cnt == LW'(LOCK_COUNT)) ? r_lock_cnt : r_lock_cnt + 1'b1;
    end

    // COUNTER is only consumed in EVAL, after the window has been frozen for SETTLE_CYCLES
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sample     <= '0;
            r_code       <= CODE_W'(1) << (CODE_W - 1);
            r_lock_cnt   <= '0;
            r_count_done <= 1'b1;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_sync1 <= i_counter;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (!i_en && r_state != IDLE && r_state != EVAL) begin
                r_state      <= IDLE;
                r_count_done <= 1'b1;
                r_lock_cnt   <= '0;
                r_locked     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= i_en ? CLEAR : IDLE;
                        r_cnt   <= '0;
                    end
                    CLEAR: begin
                        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
                        if (w_last) begin
                            r_state      <= COUNT;
                            r_count_done <= 1'b0;
                        end
                    end
                    COUNT: begin
                        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
                        if (w_last) begin
                            r_state      <= SETTLE;
                            r_count_done <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
                        if (w_last)
                            r_state <= EVAL;
                    end
                    EVAL: begin
                        r_state  <= i_en ? CLEAR : IDLE;
                        r_cnt    <= '0;
                        r_sample <= r_sync2;
                        r_valid  <= 1'b1;
                        if (w_hi || w_lo) begin
                            r_code     <= (w_hi && !w_code_min) ? r_code - 1'b1 :
                                          (w_lo && !w_code_max) ? r_code + 1'b1 : r_code;
                            r_lock_cnt <= '0;
                            r_locked   <= 1'b0;
                        end else begin
                            r_lock_cnt <= w_lock_nxt;
                            r_locked   <= w_lock_nxt == LW'(LOCK_COUNT);
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_count_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_count_done   = r_count_done;
    assign o_ctrl_code    = r_code;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;
    assign o_locked       = r_locked;
endmodule

// File: tb/tb_osc_window_controller.sv
// tb_osc_window_controller: directed checks of window timing, code stepping, lock, saturation, EN drop and reset
module tb_osc_window_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] target = '0;
    logic [3:0] tol = '0;
    logic [7:0] counter = '0;
    logic       count_done, sample_valid, locked;
    logic [5:0] ctrl_code;
    logic [7:0] sample;
    int         checks = 0;
    int         failures = 0;
    int         n;

    osc_window_controller dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_target(target), .i_tol(tol), .i_counter(counter),
        .o_count_done(count_done), .o_ctrl_code(ctrl_code), .o_sample(sample),
        .o_sample_valid(sample_valid), .o_locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // which: 0 = count_done low, 1 = count_done high, 2 = sample_valid; n = negedges waited or -1
    task automatic wait_for(input int which, input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && !count_done) || (which == 1 && count_done) || (which == 2 && sample_valid)) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic evals(input int k);
        int m;
        for (int i = 0; i < k; i++) begin
            wait_for(2, 300, m);
            if (m < 0) begin
                check("eval_timeout", m, 0);
                return;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_count_done", count_done, 1);
        check("rst_code", ctrl_code, 32);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_locked", locked, 0);

        rst = 1'b0; counter = 8'd120; target = 8'd100; tol = 4'd2; en = 1'b1;
        wait_for(0, 50, n);
        check("clear_len", n - 1, 4);
        wait_for(1, 300, n);
        check("window_len", n, 200);
        wait_for(2, 50, n);
        check("settle_to_valid", n, 5);
        check("hi_sample", sample, 120);
        check("hi_code1", ctrl_code, 31);
        check("hi_locked1", locked, 0);
        @(negedge clk);
        check("valid_width", sample_valid, 0);
        wait_for(2, 300, n);
        check("period", n + 1, 209);
        check("hi_code2", ctrl_code, 30);
        check("hi_locked2", locked, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; counter = 8'd101;
        for (int k = 1; k <= 3; k++) begin
            evals(1);
            check("lock_code", ctrl_code, 32);
            check("lock_flag", locked, (k == 3) ? 1 : 0);
        end

        wait_for(0, 300, n);
        repeat (49) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drop_count_done", count_done, 1);
        check("drop_locked", locked, 0);
        check("drop_code", ctrl_code, 32);
        check("drop_sample", sample, 101);
        wait_for(2, 400, n);
        check("drop_no_valid", n, -1);

        counter = 8'd102; en = 1'b1;
        evals(1);
        check("tol_edge_hi_code", ctrl_code, 32);
        check("tol_edge_hi_locked", locked, 0);
        counter = 8'd97;
        evals(1);
        check("tol_out_lo_code", ctrl_code, 33);
        counter = 8'd98;
        evals(1);
        check("tol_edge_lo_code", ctrl_code, 33);

        counter = 8'd0; target = 8'd200;
        evals(40);
        check("sat_hi_code", ctrl_code, 63);
        check("sat_hi_locked", locked, 0);
        counter = 8'd255; target = 8'd0;
        evals(70);
        check("sat_lo_code", ctrl_code, 0);
        check("sat_lo_locked", locked, 0);

        counter = 8'd0; target = 8'd200;
        evals(40);
        check("climb_code", ctrl_code, 40);
        counter = 8'd101; target = 8'd100;
        evals(3);
        check("pre_rst_locked", locked, 1);
        check("pre_rst_code", ctrl_code, 40);
        wait_for(0, 300, n);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_code", ctrl_code, 32);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_count_done", count_done, 1);
        check("mid_rst_sample", sample, 0);
        check("mid_rst_valid", sample_valid, 0);
        rst = 1'b0; en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/osc_window_controller.md
Name: osc_window_controller

Overview:
- System-clock-side partner of the oscillator counter: generates the COUNT_DONE gating window, reads back the frozen COUNTER value, and closes the loop by stepping the current-source control code.
- Each measurement cycle runs clear → count window → settle → evaluate. The sampled count is compared with TARGET ± TOL. The code is stepped one LSB per evaluation until lock.
- Sits in loop_top between the oscillator counter and the current-source DAC.

Parameters:
- CNT_W, 8, width of COUNTER/TARGET
- CODE_W, 6, width of CTRL_CODE
- WINDOW_CYCLES, 200, CLK cycles COUNT_DONE is held low per measurement (1..65535)
- CLEAR_CYCLES, 4, CLK cycles COUNT_DONE held high before window (>=2)
- SETTLE_CYCLES, 4, CLK cycles after window before sampling (>=3, covers 2-flop sync)
- LOCK_COUNT, 3, consecutive in-tolerance evaluations required to assert LOCKED (>=1)

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- EN  input  1  run measurement loop; sampled every cycle
- TARGET  input  CNT_W  desired COUNTER value per window; static while EN=1
- TOL  input  4  allowed |SAMPLE-TARGET| for in-tolerance
- COUNTER  input  CNT_W  oscillator counter result (OSC_OUT domain, asynchronous)
- COUNT_DONE  output  1  registered; 0 = oscillator counter counting, 1 = counter held in reset
- CTRL_CODE  output  CODE_W  current-source code (higher = more current = faster oscillator)
- SAMPLE  output  CNT_W  last captured count
- SAMPLE_VALID  output  1  one-cycle pulse when SAMPLE/CTRL_CODE update
- LOCKED  output  1  loop in tolerance for LOCK_COUNT consecutive evaluations

Behaviour:
- Reset values (RST=1 at a CLK edge): state IDLE, COUNT_DONE=1, CTRL_CODE=2^(CODE_W-1) (32), SAMPLE=0, SAMPLE_VALID=0, LOCKED=0, lock counter=0, sync flops=0. RST overrides EN.
- COUNTER passes through a 2-flop synchronizer. It is only consumed in EVAL, when the oscillator counter is frozen (COUNT_DONE has been high for >= SETTLE_CYCLES).
- FSM:
  - IDLE: COUNT_DONE=1. EN=1 → CLEAR.
  - CLEAR: COUNT_DONE=1 for exactly CLEAR_CYCLES cycles → COUNT.
  - COUNT: COUNT_DONE=0 for exactly WINDOW_CYCLES cycles → SETTLE.
  - SETTLE: COUNT_DONE=1 for exactly SETTLE_CYCLES cycles → EVAL.
  - EVAL: 1 cycle. Synchronized COUNTER is registered into SAMPLE. CTRL_CODE and LOCKED update at the same edge. SAMPLE_VALID=1 on the following cycle only. Next state is CLEAR if EN=1, else IDLE.
- COUNT_DONE is a registered state decode. It is 0 only in COUNT. Its 1→0 and 0→1 transitions align to the CLEAR→COUNT and COUNT→SETTLE edges.
- Period: one full measurement = CLEAR_CYCLES+WINDOW_CYCLES+SETTLE_CYCLES+1 CLK cycles (209 with defaults).
- Decision (9-bit signed err = SAMPLE - TARGET):
  - |err| <= TOL: code held; lock counter increments, saturating at LOCK_COUNT. LOCKED=1 when the counter reaches LOCK_COUNT.
  - err > TOL: CTRL_CODE decrements by 1, saturating at 0. Lock counter and LOCKED cleared.
  - err < -TOL: CTRL_CODE increments by 1, saturating at 2^CODE_W-1. Lock counter and LOCKED cleared.
  - Saturated with no move possible: the code is held, and lock is still cleared.
- COUNTER wrap: the oscillator counter wraps modulo 2^CNT_W. Wrap is not detected; the integrator sizes WINDOW_CYCLES so that the maximum count < 2^CNT_W.
- EN deassert mid-cycle (any state except IDLE): at the next edge go to IDLE, COUNT_DONE=1, and no evaluation. CTRL_CODE and SAMPLE hold; LOCKED and lock counter clear. Re-assert restarts from CLEAR.
- RST mid-window: immediate return to reset values on that edge, including CTRL_CODE to midscale.

Test Plan:
- Reset then EN=1, defaults → COUNT_DONE=1 for 4 cycles, 0 for exactly 200 cycles, 1 for 5 cycles; SAMPLE_VALID pulses once per 209 cycles.
- COUNTER model returns 120, TARGET=100, TOL=2 → each evaluation CTRL_CODE 32→31→30…, LOCKED stays 0; SAMPLE=120.
- COUNTER returns 101 repeatedly, TARGET=100, TOL=2 → CTRL_CODE fixed at 32; LOCKED rises on the 3rd SAMPLE_VALID, not earlier.
- Saturation: COUNTER=0, TARGET=200 for 40 evaluations → CTRL_CODE climbs to 63 and stays; LOCKED=0. Then COUNTER=255, TARGET=0 for 70 evaluations → CTRL_CODE reaches 0 and holds.
- EN dropped 50 cycles into COUNT → next edge COUNT_DONE=1, no SAMPLE_VALID, CTRL_CODE unchanged, LOCKED=0.
- RST asserted while LOCKED=1 and CTRL_CODE=40 → next edge CTRL_CODE=32, LOCKED=0, COUNT_DONE=1, SAMPLE=0.
